// File: rtl/com_player_ai.sv
// com_player_ai: computer-controlled volleyball player.
// Tracks a delayed copy of the ball in x, jumps when the ball is close
// and high enough, and reports a one-tick smash pulse while airborne.
// Optional feature macro: COM_AI_SMASH_EN (smash detection present when defined).
module com_player_ai #(
    parameter int SIDE        = 1,
    parameter int NET_X       = 160,
    parameter int GROUND_Y    = 176,
    parameter int LEFT_BOUND  = 165,
    parameter int RIGHT_BOUND = 256,
    parameter int HOME_X      = 210,
    parameter int MOVE_SPEED  = 3,
    parameter int JUMP_FORCE  = 14,
    parameter int GRAVITY     = 1,
    parameter int TOLERANCE   = 5,
    parameter int REACT_DEPTH = 2,
    parameter int JUMP_WIN    = 30,
    parameter int JUMP_Y      = 200,
    parameter int COOLDOWN    = 4,
    parameter int SMASH_DX    = 20,
    parameter int SMASH_DY    = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] level,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       is_smash,
    output logic       airborne,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_AIR    = 2'd1,
        ST_LAND   = 2'd2
    } state_t;

    // Tap index of the delay line; depth 0 bypasses the line entirely.
    localparam int DIDX = (REACT_DEPTH == 0) ? 0 : REACT_DEPTH - 1;

    function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
        absdiff = (a > b) ? (a - b) : (b - a);
    endfunction

    state_t             state_q, state_d;
    logic [9:0]         pos_x_q, pos_x_d;
    logic [9:0]         pos_y_q, pos_y_d;
    logic signed [10:0] vel_y_q, vel_y_d;
    logic [7:0]         cool_q, cool_d;
    logic               airborne_q;
    logic [2:0]         fill_q;
    logic [9:0]         dlx_q [0:7];
    logic [9:0]         dly_q [0:7];

    logic [9:0]         bx_d_s, by_d_s;
    logic               full_s, own_s, jump_ok_s, land_s;
    logic               move_r_s, move_l_s;
    logic [10:0]        tgt_s, step_s, px_ext_s;
    logic signed [10:0] ny_s;

    // Reaction delay line and fill counter; both advance only on enabled ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                dlx_q[i] <= 10'd0;
                dly_q[i] <= 10'd0;
            end
        end else if (enable) begin
            if (!full_s) begin
                fill_q <= fill_q + 3'd1;
            end else begin
                fill_q <= fill_q;
            end
            dlx_q[0] <= ball_x;
            dly_q[0] <= ball_y;
            for (int i = 1; i < 8; i++) begin
                dlx_q[i] <= dlx_q[i-1];
                dly_q[i] <= dly_q[i-1];
            end
        end else begin
            fill_q <= fill_q;
        end
    end

    // Decision datapath: delayed ball, target x, move direction, jump and landing tests.
    always_comb begin
        if (REACT_DEPTH == 0) begin
            bx_d_s = ball_x;
            by_d_s = ball_y;
        end else begin
            bx_d_s = dlx_q[DIDX];
            by_d_s = dly_q[DIDX];
        end
        full_s    = (fill_q == 3'(REACT_DEPTH));
        own_s     = (SIDE == 1) ? (bx_d_s > 10'(NET_X)) : (bx_d_s < 10'(NET_X));
        tgt_s     = (full_s && own_s) ? {1'b0, bx_d_s} : 11'(HOME_X);
        step_s    = 11'(MOVE_SPEED) * ({9'd0, level} + 11'd1);
        px_ext_s  = {1'b0, pos_x_q};
        move_r_s  = tgt_s > (px_ext_s + 11'(TOLERANCE));
        move_l_s  = (tgt_s + 11'(TOLERANCE)) < px_ext_s;
        jump_ok_s = full_s && own_s && (absdiff(bx_d_s, pos_x_q) < 10'(JUMP_WIN))
                    && (by_d_s < 10'(JUMP_Y));
        ny_s      = $signed({1'b0, pos_y_q}) + vel_y_q;
        land_s    = (ny_s >= $signed(11'(GROUND_Y))) && (vel_y_q > 11'sd0);
    end

    // Next-state logic: x tracking in every state plus the jump FSM.
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vel_y_d = vel_y_q;
        cool_d  = cool_q;
        // Bounds are compared in 11 bits so neither direction can wrap.
        if (move_r_s) begin
            if ((px_ext_s + step_s) > 11'(RIGHT_BOUND)) begin
                pos_x_d = 10'(RIGHT_BOUND);
            end else begin
                pos_x_d = pos_x_q + step_s[9:0];
            end
        end else if (move_l_s) begin
            if (px_ext_s < (step_s + 11'(LEFT_BOUND))) begin
                pos_x_d = 10'(LEFT_BOUND);
            end else begin
                pos_x_d = pos_x_q - step_s[9:0];
            end
        end else begin
            pos_x_d = pos_x_q;
        end
        case (state_q)
            ST_GROUND: begin
                if (jump_ok_s) begin
                    state_d = ST_AIR;
                    vel_y_d = 11'(-JUMP_FORCE);
                end else begin
                    state_d = ST_GROUND;
                end
            end
            ST_AIR: begin
                if (land_s) begin
                    pos_y_d = 10'(GROUND_Y);
                    vel_y_d = 11'sd0;
                    state_d = ST_LAND;
                    cool_d  = 8'(COOLDOWN);
                end else begin
                    pos_y_d = ny_s[10] ? 10'd0 : ny_s[9:0];
                    vel_y_d = vel_y_q + 11'(GRAVITY);
                end
            end
            ST_LAND: begin
                if (cool_q <= 8'd1) begin
                    state_d = ST_GROUND;
                end else begin
                    cool_d = cool_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_GROUND;
            end
        endcase
    end

    // Player state registers; reset wins over enable, disabled ticks freeze everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_GROUND;
            pos_x_q    <= 10'(HOME_X);
            pos_y_q    <= 10'(GROUND_Y);
            vel_y_q    <= 11'sd0;
            cool_q     <= 8'd0;
            airborne_q <= 1'b0;
        end else if (enable) begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vel_y_q    <= vel_y_d;
            cool_q     <= cool_d;
            airborne_q <= (state_d == ST_AIR);
        end else begin
            state_q    <= state_q;
            airborne_q <= airborne_q;
        end
    end

`ifdef COM_AI_SMASH_EN
    logic used_q, used_d, smash_hit_s, smash_q;

    // Smash detection against the live ball; a landing on the same tick suppresses it.
    always_comb begin
        smash_hit_s = 1'b0;
        used_d      = used_q;
        if (state_q == ST_GROUND) begin
            used_d = jump_ok_s ? 1'b0 : used_q;
        end else if ((state_q == ST_AIR) && !land_s && !used_q
                     && (absdiff(ball_x, pos_x_q) < 10'(SMASH_DX))
                     && (absdiff(ball_y, pos_y_q) < 10'(SMASH_DY))) begin
            smash_hit_s = 1'b1;
            used_d      = 1'b1;
        end else begin
            used_d = used_q;
        end
    end

    // Smash pulse register and one-per-jump flag; pulse is forced low on disabled ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            used_q  <= 1'b0;
            smash_q <= 1'b0;
        end else if (enable) begin
            used_q  <= used_d;
            smash_q <= smash_hit_s;
        end else begin
            used_q  <= used_q;
            smash_q <= 1'b0;
        end
    end

    assign is_smash = smash_q;
`else
    assign is_smash = 1'b0;
`endif

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign state    = state_q;
    assign airborne = airborne_q;

endmodule

// File: tb/tb_com_player_ai.sv
// Testbench for com_player_ai (default parameters). A reference model
// pushes the expected outputs for every tick into a queue; a monitor pops
// and compares after each clock edge. Directed scenarios add fixed-value checks.
module tb_com_player_ai;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] level = 2'd0;
    logic [9:0] ball_x = 10'd0;
    logic [9:0] ball_y = 10'd0;
    logic [9:0] pos_x, pos_y;
    logic       is_smash, airborne;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    localparam int D = 2;

    com_player_ai dut (
        .clk(clk), .rst(rst), .enable(enable), .level(level),
        .ball_x(ball_x), .ball_y(ball_y),
        .pos_x(pos_x), .pos_y(pos_y), .is_smash(is_smash),
        .airborne(airborne), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px;
        int py;
        int st;
        int sm;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (game-level quantities, plain integers).
    int m_px = 210, m_py = 176, m_vy = 0, m_st = 0, m_cd = 0, m_sm = 0, m_used = 0;
    int hx[$];
    int hy[$];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_step(input bit r, input bit en, input int lv,
                                       input int bx, input int by);
        int dbx, dby, tgt, stp, npx, ny;
        bit full, own, hit;
        if (r) begin
            m_px = 210; m_py = 176; m_vy = 0; m_st = 0; m_cd = 0; m_sm = 0; m_used = 0;
            hx.delete(); hy.delete();
            return;
        end
        if (!en) begin
            m_sm = 0;
            return;
        end
        full = (hx.size() >= D);
        if (D == 0) begin
            dbx = bx; dby = by;
        end else if (full) begin
            dbx = hx[D-1]; dby = hy[D-1];
        end else begin
            dbx = 0; dby = 0;
        end
        own = (dbx > 160);
        tgt = (full && own) ? dbx : 210;
        stp = 3 * (lv + 1);
        if (tgt > m_px + 5)      npx = (m_px + stp > 256) ? 256 : m_px + stp;
        else if (tgt < m_px - 5) npx = (m_px - stp < 165) ? 165 : m_px - stp;
        else                     npx = m_px;
        hit = 1'b0;
        if (m_st == 0) begin
            if (full && own && iabs(dbx - m_px) < 30 && dby < 200) begin
                m_st = 1; m_vy = -14; m_used = 0;
            end
        end else if (m_st == 1) begin
            ny = m_py + m_vy;
            if (ny >= 176 && m_vy > 0) begin
                m_py = 176; m_vy = 0; m_st = 2; m_cd = 4;
            end else begin
`ifdef COM_AI_SMASH_EN
                hit = (m_used == 0) && iabs(bx - m_px) < 20 && iabs(by - m_py) < 40;
                if (hit) m_used = 1;
`endif
                m_py = (ny < 0) ? 0 : ny;
                m_vy = m_vy + 1;
            end
        end else begin
            if (m_cd == 1) m_st = 0;
            else           m_cd = m_cd - 1;
        end
        m_sm = hit ? 1 : 0;
        m_px = npx;
        hx.push_front(bx); hy.push_front(by);
        if (hx.size() > D) begin
            void'(hx.pop_back());
            void'(hy.pop_back());
        end
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Drive one tick's inputs, advance the model and queue the expected outputs.
    task automatic drive(input bit r, input bit en, input int lv, input int bx, input int by);
        exp_t e;
        @(negedge clk);
        rst = r; enable = en; level = 2'(lv); ball_x = 10'(bx); ball_y = 10'(by);
        model_step(r, en, lv, bx, by);
        e.px = m_px; e.py = m_py; e.st = m_st; e.sm = m_sm;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every clock edge compare the DUT with the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pos_x", int'(pos_x), e.px);
            chk("pos_y", int'(pos_y), e.py);
            chk("state", int'(state), e.st);
            chk("airborne", int'(airborne), (e.st == 1) ? 1 : 0);
            chk("is_smash", int'(is_smash), e.sm);
        end
    end

    initial begin
        int pulses, ymin, hold, bx, by, lv, en;
`ifdef COM_AI_SMASH_EN
        int exp_pulses = 1;
`else
        int exp_pulses = 0;
`endif
        // Reset state.
        drive(1'b1, 1'b0, 0, 0, 0);
        settle();
        chk("reset_pos_x", int'(pos_x), 210);
        chk("reset_pos_y", int'(pos_y), 176);
        chk("reset_state", int'(state), 0);

        // Level 0 tracking to 246 with no jump.
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 0, 250, 220);
        settle();
        chk("track_l0_x", int'(pos_x), 246);
        chk("track_l0_state", int'(state), 0);

        // Level 3 tracking clamps at the right bound.
        drive(1'b1, 1'b1, 3, 300, 220);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 3, 300, 220);
        settle();
        chk("clamp_right_x", int'(pos_x), 256);

        // Full jump arc, landing, cooldown and immediate re-jump.
        drive(1'b1, 1'b1, 0, 215, 150);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 0, 215, 150);
        settle();
        chk("jump_start_state", int'(state), 1);
        chk("jump_start_y", int'(pos_y), 176);
        pulses = int'(is_smash);
        ymin = 1023;
        for (int i = 1; i <= 29; i++) begin
            drive(1'b0, 1'b1, 0, 215, 150);
            settle();
            if (int'(pos_y) < ymin) ymin = int'(pos_y);
            pulses += int'(is_smash);
            if (i == 14) chk("apex_y", int'(pos_y), 71);
        end
        chk("jump_min_y", ymin, 71);
        chk("land_y", int'(pos_y), 176);
        chk("land_state", int'(state), 2);
        chk("smash_pulses", pulses, exp_pulses);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 0, 215, 150);
        settle();
        chk("cooldown_state", int'(state), 2);
        drive(1'b0, 1'b1, 0, 215, 150);
        settle();
        chk("ground_state", int'(state), 0);
        drive(1'b0, 1'b1, 0, 215, 150);
        settle();
        chk("rejump_state", int'(state), 1);

        // Reset in mid-air, then no jump until the delay line refills.
        drive(1'b1, 1'b1, 0, 215, 150);
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 0, 215, 150);
        drive(1'b1, 1'b1, 0, 215, 150);
        settle();
        chk("midair_rst_x", int'(pos_x), 210);
        chk("midair_rst_y", int'(pos_y), 176);
        chk("midair_rst_state", int'(state), 0);
        chk("midair_rst_air", int'(airborne), 0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 0, 215, 150);
        settle();
        chk("refill_no_jump", int'(state), 0);

        // Ball on the far side: walk back home and stop at 213; disabled ticks freeze.
        drive(1'b1, 1'b1, 0, 250, 220);
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 0, 250, 220);
        for (int i = 0; i < 25; i++) drive(1'b0, 1'b1, 0, 100, 150);
        settle();
        chk("home_x", int'(pos_x), 213);
        chk("home_state", int'(state), 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 0, 215, 150);
        settle();
        chk("frozen_x", int'(pos_x), 213);
        chk("frozen_state", int'(state), 0);

        // Randomized play against the model.
        drive(1'b1, 1'b1, 0, 0, 0);
        for (int n = 0; n < 150; n++) begin
            hold = $urandom_range(1, 30);
            lv = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                bx = m_px + $urandom_range(0, 30) - 15;
                by = $urandom_range(60, 199);
            end else begin
                bx = $urandom_range(100, 320);
                by = $urandom_range(0, 300);
            end
            for (int k = 0; k < hold; k++) begin
                en = ($urandom_range(0, 9) == 0) ? 0 : 1;
                drive(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, en[0], lv, bx, by);
            end
        end

        // Let the monitor drain the queue within a bounded number of edges.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) settle();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/com_player_ai.md
COM_PLAYER_AI -- requirements
Module: com_player_ai

Interface
REQ-001 Parameter SIDE, default 1, meaning court side owned (1 = right of net, 0 = left).
REQ-002 Parameter NET_X, default 160, meaning net x-coordinate.
REQ-003 Parameters GROUND_Y 176, LEFT_BOUND 165, RIGHT_BOUND 256, HOME_X 210, meaning rest height, x clamp limits and home x.
REQ-004 Parameters MOVE_SPEED 3, JUMP_FORCE 14, GRAVITY 1, TOLERANCE 5, meaning base step, jump launch speed, per-tick gravity and x dead-band.
REQ-005 Parameters REACT_DEPTH 2 (0..7), JUMP_WIN 30, JUMP_Y 200, COOLDOWN 4, SMASH_DX 20, SMASH_DY 40, meaning reaction delay, jump window, jump height gate, post-landing lockout and smash box.
REQ-006 clk  input  1  game tick clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 enable  input  1  AI runs when high; all state frozen when low.
REQ-009 level  input  2  difficulty; x step = MOVE_SPEED*(level+1).
REQ-010 ball_x, ball_y  input  10 each  live ball position.
REQ-011 pos_x, pos_y  output  10 each  player position.
REQ-012 is_smash  output  1  one-cycle smash pulse.
REQ-013 airborne  output  1  high in AIR state.
REQ-014 state  output  2  FSM state code (GROUND=0, AIR=1, LAND=2).

Function
REQ-015 Reaction delay line SHALL present (bx_d, by_d) = ball sample from REACT_DEPTH ticks earlier; REACT_DEPTH=0 SHALL pass the live ball through.
REQ-016 Fill counter SHALL count enabled ticks up to REACT_DEPTH; until full, target x SHALL be HOME_X and jumps SHALL be inhibited.
REQ-017 Own side: SIDE=1 -> bx_d > NET_X; SIDE=0 -> bx_d < NET_X; target x = bx_d if own side, else HOME_X.
REQ-018 X move each enabled tick, in any state: target > pos_x+TOLERANCE -> pos_x = min(pos_x+step, RIGHT_BOUND); target < pos_x-TOLERANCE -> pos_x = max(pos_x-step, LEFT_BOUND); else hold.
REQ-019 X arithmetic SHALL be 11-bit unsigned before clamping; no wrap-around at either bound.
REQ-020 GROUND -> AIR when own side, |bx_d-pos_x| < JUMP_WIN, by_d < JUMP_Y; vel_y = -JUMP_FORCE; pos_y unchanged that tick.
REQ-021 AIR: ny = pos_y+vel_y (11-bit signed); if ny >= GROUND_Y and vel_y > 0 -> pos_y = GROUND_Y, vel_y = 0, go LAND with cooldown = COOLDOWN; else pos_y = max(ny,0), vel_y += GRAVITY.
REQ-022 LAND: cooldown decrements each enabled tick; at 1 -> GROUND; no jump while in LAND.
REQ-023 Smash: in AIR, live ball within |ball_x-pos_x| < SMASH_DX and |ball_y-pos_y| < SMASH_DY -> is_smash = 1 for exactly one tick; at most one pulse per jump.
REQ-024 is_smash SHALL be 0 in GROUND, LAND, and on any tick with enable low.
REQ-025 Landing and smash hit on same tick: landing wins, is_smash = 0.

Reset
REQ-026 rst on clk edge, in any state including mid-air: pos_x = HOME_X, pos_y = GROUND_Y, vel_y = 0, state GROUND, is_smash 0, airborne 0, fill counter 0, delay line cleared, smash-used flag cleared.
REQ-027 rst SHALL take priority over enable.

Configuration
REQ-028 Macro COM_AI_SMASH_EN defined: smash logic per REQ-023..025 present.
REQ-029 Macro COM_AI_SMASH_EN undefined: smash logic removed, is_smash tied 0, all other behaviour identical.

Verification
REQ-030 Defaults, level 0, ball held (250,220): after 2-tick fill, pos_x 210,213,...,246 then holds; no jump.
REQ-031 Level 3, ball held (300,220): pos_x 210,222,234,246,256, holds at 256 (clamp).
REQ-032 Ball held (215,150): jump; pos_y minimum 71; pos_y = 176 on 29th AIR tick; 4 LAND ticks, no re-jump during LAND; re-jumps on first GROUND tick.
REQ-033 Macro defined, ball held inside smash box during full jump: exactly one is_smash pulse; macro undefined: is_smash never 1.
REQ-034 rst asserted on 10th AIR tick: next tick pos (210,176), state 0, airborne 0; no jump until fill completes.
REQ-035 Ball held (100,150), pos_x 240 (SIDE=1): pos_x steps down by 3 to 213 and holds, no jump; enable low for 5 ticks freezes all outputs.
